// File: rtl/regfile_wb_arb_pkg.sv
// Shared definitions for the register-file writeback arbiter: default widths,
// requester indices and the grant encoding used by the top level.
package regfile_wb_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_ALU  = 2'd1,
    GRANT_LOAD = 2'd2
  } grant_e;

endpackage

// File: rtl/regfile_wb_arb_wb_slot.sv
// One-entry holding slot for a writeback requester. The older flag records
// that the other slot was filled after this one, so acceptance order is kept.
module wb_slot #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              grant,
  input  logic              other_load,
  output logic              req_ready,
  output logic              load,
  output logic              slot_valid,
  output logic [ADDR_W-1:0] slot_addr,
  output logic [DATA_W-1:0] slot_data,
  output logic              slot_older
);

  // A granted slot drains on the same edge it may be refilled.
  assign req_ready = !slot_valid || grant;
  assign load      = req_valid && req_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid <= 1'b0;
      slot_addr  <= '0;
      slot_data  <= '0;
      slot_older <= 1'b0;
    end else if (load) begin
      slot_valid <= 1'b1;
      slot_addr  <= req_addr;
      slot_data  <= req_data;
      slot_older <= 1'b0;
    end else if (grant) begin
      slot_valid <= 1'b0;
      slot_older <= 1'b0;
    end else if (slot_valid && other_load) begin
      slot_older <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arb.sv
// Two-requester writeback arbiter in front of a register-file write port:
// oldest-first grant, registered write outputs and a pending-register mask.
module regfile_wb_arb
  import regfile_wb_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   req0_valid,
  input  logic [ADDR_W-1:0]      req0_addr,
  input  logic [DATA_W-1:0]      req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [ADDR_W-1:0]      req1_addr,
  input  logic [DATA_W-1:0]      req1_data,
  output logic                   req1_ready,
  output logic [ADDR_W-1:0]      a3,
  output logic [DATA_W-1:0]      wd3,
  output logic                   we3,
  output logic [(1<<ADDR_W)-1:0] pend
);

  logic [1:0]        slot_valid;
  logic [1:0]        slot_older;
  logic [1:0]        slot_load;
  logic [1:0]        slot_grant;
  logic [ADDR_W-1:0] slot_addr [2];
  logic [DATA_W-1:0] slot_data [2];

  grant_e            grant;
  logic              win;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_alu (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req0_valid),
    .req_addr   (req0_addr),
    .req_data   (req0_data),
    .grant      (slot_grant[REQ_ALU]),
    .other_load (slot_load[REQ_LOAD]),
    .req_ready  (req0_ready),
    .load       (slot_load[REQ_ALU]),
    .slot_valid (slot_valid[REQ_ALU]),
    .slot_addr  (slot_addr[REQ_ALU]),
    .slot_data  (slot_data[REQ_ALU]),
    .slot_older (slot_older[REQ_ALU])
  );

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_load (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req1_valid),
    .req_addr   (req1_addr),
    .req_data   (req1_data),
    .grant      (slot_grant[REQ_LOAD]),
    .other_load (slot_load[REQ_ALU]),
    .req_ready  (req1_ready),
    .load       (slot_load[REQ_LOAD]),
    .slot_valid (slot_valid[REQ_LOAD]),
    .slot_addr  (slot_addr[REQ_LOAD]),
    .slot_data  (slot_data[REQ_LOAD]),
    .slot_older (slot_older[REQ_LOAD])
  );

  // The load slot wins only when it is strictly older; ties go to the ALU slot.
  always_comb begin
    grant = GRANT_NONE;
    if (slot_valid[REQ_LOAD] &&
        (!slot_valid[REQ_ALU] || (slot_older[REQ_LOAD] && !slot_older[REQ_ALU])))
      grant = GRANT_LOAD;
    else if (slot_valid[REQ_ALU])
      grant = GRANT_ALU;
  end

  assign slot_grant[REQ_ALU]  = (grant == GRANT_ALU);
  assign slot_grant[REQ_LOAD] = (grant == GRANT_LOAD);
  assign win      = (grant != GRANT_NONE);
  assign sel_addr = (grant == GRANT_LOAD) ? slot_addr[REQ_LOAD] : slot_addr[REQ_ALU];
  assign sel_data = (grant == GRANT_LOAD) ? slot_data[REQ_LOAD] : slot_data[REQ_ALU];

  // A granted write to register 0 is dropped; a3/wd3 keep their last values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a3  <= '0;
      wd3 <= '0;
      we3 <= 1'b0;
    end else begin
      we3 <= win && (sel_addr != '0);
      if (win && (sel_addr != '0)) begin
        a3  <= sel_addr;
        wd3 <= sel_data;
      end
    end
  end

  always_comb begin
    pend = '0;
    if (slot_valid[REQ_ALU] && (slot_addr[REQ_ALU] != '0))
      pend[slot_addr[REQ_ALU]] = 1'b1;
    if (slot_valid[REQ_LOAD] && (slot_addr[REQ_LOAD] != '0))
      pend[slot_addr[REQ_LOAD]] = 1'b1;
  end

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Testbench for regfile_wb_arb: directed scenarios then random traffic, each
// cycle compared against a timestamp-ordered model of the two holding slots.
module tb_regfile_wb_arb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 1 << AW;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;
  logic          we3;
  logic [NR-1:0] pend;

  always #5 clock = ~clock;

  regfile_wb_arb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .a3         (a3),
    .wd3        (wd3),
    .we3        (we3),
    .pend       (pend)
  );

  // Each held request carries its acceptance timestamp; the lowest one retires first.
  typedef struct {
    bit            v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int unsigned   seq;
  } mslot_t;

  mslot_t        m [2];
  int unsigned   seq_ctr;
  bit            m_we3;
  logic [AW-1:0] m_a3;
  logic [DW-1:0] m_wd3;
  int            compared;
  int            mismatched;

  function automatic int model_grant();
    if (m[0].v && m[1].v) return (m[1].seq < m[0].seq) ? 1 : 0;
    if (m[0].v) return 0;
    if (m[1].v) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].v = 0; m[i].a = '0; m[i].d = '0; m[i].seq = 0;
    end
    seq_ctr = 0;
    m_we3 = 0; m_a3 = '0; m_wd3 = '0;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check ready/pend before the edge, write port after it.
  task automatic apply_stimulus(input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int            g;
    bit            r0, r1;
    logic [NR-1:0] pe;
    @(negedge clock);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    g  = model_grant();
    r0 = !m[0].v || (g == 0);
    r1 = !m[1].v || (g == 1);
    pe = '0;
    for (int i = 0; i < 2; i++)
      if (m[i].v && m[i].a != '0) pe[m[i].a] = 1'b1;
    check_output("req0_ready", 64'(req0_ready), 64'(r0));
    check_output("req1_ready", 64'(req1_ready), 64'(r1));
    check_output("pend", 64'(pend), 64'(pe));
    @(posedge clock);
    m_we3 = 0;
    if (g >= 0) begin
      if (m[g].a != '0) begin
        m_we3 = 1; m_a3 = m[g].a; m_wd3 = m[g].d;
      end
      m[g].v = 0;
    end
    if (v0 && r0) begin m[0].v = 1; m[0].a = a0; m[0].d = d0; m[0].seq = seq_ctr++; end
    if (v1 && r1) begin m[1].v = 1; m[1].a = a1; m[1].d = d1; m[1].seq = seq_ctr++; end
    #1;
    check_output("we3", 64'(we3), 64'(m_we3));
    check_output("a3", 64'(a3), 64'(m_a3));
    check_output("wd3", 64'(wd3), 64'(m_wd3));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    model_reset();
    reset_n = 1'b0;
    req0_valid = 0; req0_addr = '0; req0_data = '0;
    req1_valid = 0; req1_addr = '0; req1_data = '0;
    #12;
    check_output("reset_we3", 64'(we3), 64'(0));
    check_output("reset_a3", 64'(a3), 64'(0));
    check_output("reset_wd3", 64'(wd3), 64'(0));
    check_output("reset_pend", 64'(pend), 64'(0));
    check_output("reset_ready0", 64'(req0_ready), 64'(1));
    check_output("reset_ready1", 64'(req1_ready), 64'(1));
    @(negedge clock);
    reset_n = 1'b1;

    // Single write to r8.
    apply_stimulus(1, 5'd8, 32'h0000_00AA, 0, '0, '0);
    idle(3);

    // Simultaneous requests to r9 and r10.
    apply_stimulus(1, 5'd9, 32'd1, 1, 5'd10, 32'd2);
    idle(3);

    // Same-register ordering: load first, then ALU.
    apply_stimulus(0, '0, '0, 1, 5'd5, 32'h11);
    apply_stimulus(1, 5'd5, 32'h22, 0, '0, '0);
    idle(3);

    // Register zero is never written.
    apply_stimulus(1, 5'd0, 32'hFFFF_FFFF, 0, '0, '0);
    idle(3);

    // Both requesters streaming.
    for (int i = 0; i < 10; i++)
      apply_stimulus(1, AW'(i + 1), 32'h100 + i, 1, AW'(i + 12), 32'h200 + i);
    idle(3);

    // Asynchronous reset with both slots occupied.
    apply_stimulus(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
    apply_stimulus(1, 5'd6, 32'h66, 0, '0, '0);
    #2;
    req0_valid = 0; req1_valid = 0;
    reset_n = 1'b0;
    #1;
    check_output("async_rst_we3", 64'(we3), 64'(0));
    check_output("async_rst_pend", 64'(pend), 64'(0));
    check_output("async_rst_ready0", 64'(req0_ready), 64'(1));
    check_output("async_rst_ready1", 64'(req1_ready), 64'(1));
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    idle(3);

    // Random traffic over a small address range to provoke collisions.
    for (int i = 0; i < 400; i++)
      apply_stimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
                     1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
